// File: rtl/trng_health_test.sv
// Online health monitor for the TRNG word stream: repetition-count and adaptive-proportion
// tests, startup gating, and a sticky alarm that blocks forwarding until reset.
module trng_health_test #(
    parameter int RCT_CUTOFF    = 4,
    parameter int APT_WINDOW    = 64,
    parameter int APT_LO        = 896,
    parameter int APT_HI        = 1152,
    parameter int STARTUP_WORDS = 64
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        healthy,
    output logic        alarm,
    output logic        rct_fail,
    output logic        apt_fail
);

    localparam int SUM_W = $clog2(APT_WINDOW * 32 + 1);
    localparam int WIN_W = $clog2(APT_WINDOW + 1);
    localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
    localparam int ST_W  = $clog2(STARTUP_WORDS + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(APT_WINDOW - 1);
    localparam logic [SUM_W-1:0] SUM_LO   = SUM_W'(APT_LO);
    localparam logic [SUM_W-1:0] SUM_HI   = SUM_W'(APT_HI);
    localparam logic [RCT_W-1:0] RCT_LIM  = RCT_W'(RCT_CUTOFF);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STARTUP_WORDS - 1);

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        RUN     = 2'd1,
        ALARM   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      prev_word;
    logic [RCT_W-1:0] rct_cnt;
    logic [SUM_W-1:0] ones_sum;
    logic [WIN_W-1:0] win_cnt;
    logic [ST_W-1:0]  st_cnt;
    logic [31:0]      data_p1;
    logic             vld_p1;
    logic             rct_flag, apt_flag;

    logic             acc, win_end, rct_trip, apt_trip, fail, fwd;
    logic [5:0]       pop;
    logic [RCT_W-1:0] rct_nxt;
    logic [SUM_W-1:0] apt_total;

    function automatic logic [5:0] popcount32(input logic [31:0] d);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {5'd0, d[i]};
        return c;
    endfunction

    // Test evaluation on the incoming word; a failure is decided in the same cycle
    always_comb begin
        acc       = in_valid && (state != ALARM);
        pop       = popcount32(in_data);
        rct_nxt   = (rct_cnt != '0 && in_data == prev_word) ? rct_cnt + RCT_W'(1) : RCT_W'(1);
        apt_total = ones_sum + SUM_W'(pop);
        win_end   = (win_cnt == WIN_LAST);
        rct_trip  = acc && (rct_nxt == RCT_LIM);
        apt_trip  = acc && win_end && (apt_total < SUM_LO || apt_total > SUM_HI);
        fail      = rct_trip || apt_trip;
        fwd       = acc && !fail && (state == RUN);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            STARTUP: begin
                if (fail)                            state_nxt = ALARM;
                else if (acc && st_cnt == ST_LAST)   state_nxt = RUN;
            end
            RUN:     if (fail) state_nxt = ALARM;
            ALARM:   state_nxt = ALARM;
            default: state_nxt = STARTUP;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) state <= STARTUP;
        else     state <= state_nxt;
    end

    // Registered test state and output stage (_p1)
    always_ff @(posedge clk_in) begin
        if (rst) begin
            prev_word <= '0;
            rct_cnt   <= '0;
            ones_sum  <= '0;
            win_cnt   <= '0;
            st_cnt    <= '0;
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            rct_flag  <= 1'b0;
            apt_flag  <= 1'b0;
        end else begin
            vld_p1 <= fwd;
            if (fwd)  data_p1 <= in_data;
            if (fail) data_p1 <= '0;
            if (rct_trip) rct_flag <= 1'b1;
            if (apt_trip) apt_flag <= 1'b1;
            if (acc) begin
                prev_word <= in_data;
                rct_cnt   <= rct_nxt;
                if (win_end) begin
                    ones_sum <= '0;
                    win_cnt  <= '0;
                end else begin
                    ones_sum <= apt_total;
                    win_cnt  <= win_cnt + WIN_W'(1);
                end
                if (state == STARTUP) st_cnt <= st_cnt + ST_W'(1);
            end
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign healthy   = (state == RUN);
    assign alarm     = (state == ALARM);
    assign rct_fail  = rct_flag;
    assign apt_fail  = apt_flag;

endmodule

// File: tb/tb_trng_health_test.sv
// Randomized bench for trng_health_test with a queue-based reference model of the
// RCT/APT rules, startup gating and alarm behaviour.
module tb_trng_health_test;

    localparam int RCT_CUTOFF    = 4;
    localparam int APT_WINDOW    = 64;
    localparam int APT_LO        = 896;
    localparam int APT_HI        = 1152;
    localparam int STARTUP_WORDS = 64;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid, healthy, alarm, rct_fail, apt_fail;

    trng_health_test #(
        .RCT_CUTOFF(RCT_CUTOFF), .APT_WINDOW(APT_WINDOW), .APT_LO(APT_LO),
        .APT_HI(APT_HI), .STARTUP_WORDS(STARTUP_WORDS)
    ) dut (
        .clk_in(clk_in), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .healthy(healthy),
        .alarm(alarm), .rct_fail(rct_fail), .apt_fail(apt_fail)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_run, m_alarm, m_rct, m_apt, m_vld;
    int          m_started;
    logic [31:0] m_data;
    logic [31:0] hist[$];
    logic [31:0] win_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_alarm = 0; m_rct = 0; m_apt = 0; m_vld = 0;
        m_started = 0; m_data = '0;
        hist.delete();
        win_q.delete();
    endfunction

    function automatic void model_word(input logic [31:0] w);
        int run, total;
        bit rctf, aptf;
        m_vld = 0;
        if (m_alarm) return;
        run = 1;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != w) break;
            run++;
        end
        hist.push_back(w);
        if (hist.size() > RCT_CUTOFF) void'(hist.pop_front());
        win_q.push_back(w);
        aptf = 0;
        if (win_q.size() == APT_WINDOW) begin
            total = 0;
            foreach (win_q[i]) total += $countones(win_q[i]);
            aptf = (total < APT_LO) || (total > APT_HI);
            win_q.delete();
        end
        rctf = (run >= RCT_CUTOFF);
        if (rctf || aptf) begin
            m_rct   = m_rct | rctf;
            m_apt   = m_apt | aptf;
            m_alarm = 1;
            m_run   = 0;
            m_data  = '0;
        end else if (!m_run) begin
            m_started++;
            if (m_started == STARTUP_WORDS) m_run = 1;
        end else begin
            m_vld  = 1;
            m_data = w;
        end
    endfunction

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out_data",  out_data,       m_data);
        check("healthy",   32'(healthy),   32'(m_run));
        check("alarm",     32'(alarm),     32'(m_alarm));
        check("rct_fail",  32'(rct_fail),  32'(m_rct));
        check("apt_fail",  32'(apt_fail),  32'(m_apt));
    endtask

    // Inputs are applied on the falling edge; outputs checked one falling edge later
    task automatic step(input bit v, input logic [31:0] d);
        in_valid = v;
        in_data  = v ? d : $urandom;
        @(posedge clk_in);
        if (v) model_word(d);
        else   m_vld = 0;
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = $urandom;
        @(posedge clk_in);
        model_reset();
        @(negedge clk_in);
        rst = 1'b0;
        compare_all();
    endtask

    task automatic feed_alt(input int n, input bit gaps);
        logic [31:0] k;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(1, 0) == 1) step(1'b0, 32'd0);
            k = 32'(i / 2 + 1);
            step(1'b1, (i % 2 == 1) ? ~k : k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        model_reset();
        @(negedge clk_in);

        // Clean startup, then forwarding of random words with a gap
        reset_dut();
        feed_alt(STARTUP_WORDS, 1'b0);
        step(1'b1, 32'h1234_5678);
        step(1'b0, 32'd0);
        for (int i = 0; i < 20; i++) step(1'b1, $urandom);

        // Constant word trips the repetition test during startup
        reset_dut();
        for (int i = 0; i < 6; i++) step(1'b1, 32'hA5A5_A5A5);
        step(1'b0, 32'd0);

        // Reset out of ALARM restarts the full startup, with gaps
        reset_dut();
        feed_alt(STARTUP_WORDS, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom);

        // Ones-heavy window in RUN trips the proportion test at window end
        reset_dut();
        feed_alt(STARTUP_WORDS, 1'b0);
        for (int i = 0; i < APT_WINDOW; i++) begin
            w = 32'hFFFF_00FF ^ ((i % 2 == 1) ? 32'h0000_0100 : 32'h0);
            step(1'b1, w);
        end
        for (int i = 0; i < 4; i++) step(1'b1, $urandom);

        // Both tests fail on the same word: 60 high-density alternating, then 4 identical
        reset_dut();
        for (int i = 0; i < APT_WINDOW - RCT_CUTOFF; i++)
            step(1'b1, (i % 2 == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        for (int i = 0; i < RCT_CUTOFF; i++) step(1'b1, 32'hFFFF_FFFF);
        step(1'b1, 32'h0F0F_0F0F);

        // RUN with random valid duty cycle
        reset_dut();
        feed_alt(STARTUP_WORDS, 1'b1);
        for (int i = 0; i < 300; i++) step($urandom_range(1, 0) == 1, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
